// File: rtl/mem_arbiter.sv
// Arbiter between instruction fetch and data memory for one single-port unified
// memory. Data wins ties, but after STARVE_LIMIT back-to-back data grants made
// while fetch was waiting, the next tie goes to fetch.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  // fetch port
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  // data port
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [3:0]  dm_wstrb,
  output logic [31:0] dm_rdata,
  output logic        dm_valid,
  // memory port
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  // pipeline stalls
  output logic        stall_fetch,
  output logic        stall_mem
);

  typedef enum logic [1:0] {StIdle, StBusyI, StBusyD} state_e;

  localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

  state_e      state_q, state_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        we_q, we_d;
  logic        busy;
  logic        fetch_turn;

  // Fetch takes a tie only once data has starved it STARVE_LIMIT times.
  assign fetch_turn = if_req && (starve_cnt_q == Limit);

  // Next-state: grant from idle (capturing the access), release on mem_ready.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    we_d         = we_q;
    case (state_q)
      StIdle: begin
        if (dm_req && !fetch_turn) begin
          state_d = StBusyD;
          addr_d  = dm_addr;
          we_d    = dm_we;
          wstrb_d = dm_we ? dm_wstrb : 4'h0;
          wdata_d = dm_wdata;
          if (if_req && (starve_cnt_q != Limit)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
          end
        end else if (if_req) begin
          state_d      = StBusyI;
          addr_d       = if_addr;
          we_d         = 1'b0;
          wstrb_d      = 4'h0;
          wdata_d      = 32'h0;
          starve_cnt_d = 4'd0;
        end
      end
      StBusyI, StBusyD: begin
        if (mem_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and captured access; reset abandons any access in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      starve_cnt_q <= 4'd0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      wstrb_q      <= 4'h0;
      we_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      we_q         <= we_d;
    end
  end

  // Memory outputs come from the captured access so they stay stable while busy.
  always_comb begin
    busy      = (state_q != StIdle);
    mem_req   = busy;
    mem_we    = busy ? we_q    : 1'b0;
    mem_addr  = busy ? addr_q  : 32'h0;
    mem_wdata = busy ? wdata_q : 32'h0;
    mem_wstrb = busy ? wstrb_q : 4'h0;
  end

  // Completion pulses and stalls are combinational from the current state.
  always_comb begin
    if_valid    = (state_q == StBusyI) && mem_ready;
    dm_valid    = (state_q == StBusyD) && mem_ready;
    if_rdata    = mem_rdata;
    dm_rdata    = mem_rdata;
    stall_fetch = if_req && !if_valid;
    stall_mem   = dm_req && !dm_valid;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural arbitration model and a
// per-cycle comparator, plus literal checks at the interesting cycles.
module tb_mem_arbiter;

  localparam int Starve = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'h0;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [31:0] dm_addr = 32'h0;
  logic [31:0] dm_wdata = 32'h0;
  logic [3:0]  dm_wstrb = 4'h0;
  logic [31:0] dm_rdata;
  logic        dm_valid;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata = 32'h0;
  logic        stall_fetch;
  logic        stall_mem;

  int vectors = 0;
  int miscompares = 0;

  mem_arbiter #(.STARVE_LIMIT(Starve)) dut (
    .clk        (clk),
    .reset      (reset),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_rdata   (if_rdata),
    .if_valid   (if_valid),
    .dm_req     (dm_req),
    .dm_we      (dm_we),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_wstrb   (dm_wstrb),
    .dm_rdata   (dm_rdata),
    .dm_valid   (dm_valid),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .stall_fetch(stall_fetch),
    .stall_mem  (stall_mem)
  );

  always #5 clk = ~clk;

  // Memory responder: ready after 'lat' busy cycles, or forced high.
  int   lat = 1;
  int   age = 0;
  logic ready_force = 1'b0;
  logic ready_lat = 1'b0;
  assign mem_ready = ready_force | ready_lat;

  // Arbitration model: owner 0 = nobody, 1 = fetch, 2 = data.
  int          owner = 0;
  int          starve = 0;
  int          starve_peak = 0;
  logic [31:0] g_addr = 32'h0;
  logic [31:0] g_wdata = 32'h0;
  logic [3:0]  g_wstrb = 4'h0;
  logic        g_we = 1'b0;
  string       grants = "";

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      owner  = 0;
      starve = 0;
    end else if (owner == 0) begin
      if (dm_req && !(if_req && starve == Starve)) begin
        owner   = 2;
        g_addr  = dm_addr;
        g_we    = dm_we;
        g_wstrb = dm_we ? dm_wstrb : 4'h0;
        g_wdata = dm_wdata;
        if (if_req) starve = starve + 1;
        grants  = {grants, "D"};
      end else if (if_req) begin
        owner   = 1;
        g_addr  = if_addr;
        g_we    = 1'b0;
        g_wstrb = 4'h0;
        g_wdata = 32'h0;
        starve  = 0;
        grants  = {grants, "I"};
      end
    end else if (mem_ready) begin
      owner = 0;
    end
    if (starve > starve_peak) starve_peak = starve;
  end

  initial forever begin
    @(posedge clk);
    #1;
    age       = (owner != 0) ? age + 1 : 0;
    ready_lat = (owner != 0) && (age > lat);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    check("m.mem_req", {31'h0, mem_req}, {31'h0, owner != 0});
    check("m.mem_we", {31'h0, mem_we}, {31'h0, (owner != 0) && g_we});
    check("m.mem_addr", mem_addr, (owner != 0) ? g_addr : 32'h0);
    check("m.mem_wdata", mem_wdata, (owner != 0) ? g_wdata : 32'h0);
    check("m.mem_wstrb", {28'h0, mem_wstrb}, {28'h0, (owner != 0) ? g_wstrb : 4'h0});
    check("m.if_valid", {31'h0, if_valid}, {31'h0, owner == 1 && mem_ready});
    check("m.dm_valid", {31'h0, dm_valid}, {31'h0, owner == 2 && mem_ready});
    check("m.if_rdata", if_rdata, mem_rdata);
    check("m.dm_rdata", dm_rdata, mem_rdata);
    check("m.stall_fetch", {31'h0, stall_fetch}, {31'h0, if_req && !(owner == 1 && mem_ready)});
    check("m.stall_mem", {31'h0, stall_mem}, {31'h0, dm_req && !(owner == 2 && mem_ready)});
  end

  task automatic drive_slot();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (owner != 0 && n < 50) begin
      drive_slot();
      n++;
    end
    check(name, {31'h0, owner != 0}, 32'h0);
  endtask

  initial begin
    int   n;
    logic seen;

    // Reset, asserted before any clock edge.
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst.mem_req", {31'h0, mem_req}, 32'h0);
    check("rst.if_valid", {31'h0, if_valid}, 32'h0);
    drive_slot();
    drive_slot();
    reset = 1'b1;
    drive_slot();

    // Fetch only, one wait cycle.
    if_req = 1'b1; if_addr = 32'h8000_0000; mem_rdata = 32'h0000_0013; lat = 1;
    @(posedge clk);
    @(negedge clk);
    check("fetch.busy_req", {31'h0, mem_req}, 32'h1);
    check("fetch.busy_addr", mem_addr, 32'h8000_0000);
    check("fetch.busy_valid", {31'h0, if_valid}, 32'h0);
    check("fetch.busy_stall", {31'h0, stall_fetch}, 32'h1);
    @(negedge clk);
    check("fetch.valid", {31'h0, if_valid}, 32'h1);
    check("fetch.rdata", if_rdata, 32'h0000_0013);
    check("fetch.valid_stall", {31'h0, stall_fetch}, 32'h0);
    drive_slot();
    if_req = 1'b0;
    @(negedge clk);
    check("fetch.idle_req", {31'h0, mem_req}, 32'h0);

    // Both requesting continuously: starvation rotation.
    drive_slot();
    grants = ""; starve_peak = 0;
    if_req = 1'b1; if_addr = 32'h8000_0010;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h8000_2000;
    n = 0;
    while (grants.len() < 10 && n < 100) begin
      drive_slot();
      n++;
    end
    if_req = 1'b0; dm_req = 1'b0;
    wait_idle("starve.settle");
    vectors++;
    if (grants != "DDDDIDDDDI") begin
      miscompares++;
      $display("FAIL starve.order: got %s expected DDDDIDDDDI", grants);
    end
    check("starve.peak", starve_peak, 32'd4);

    // Store with three wait cycles.
    drive_slot();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h8000_1004;
    dm_wstrb = 4'h3; dm_wdata = 32'hDEAD_BEEF; lat = 3;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("store.addr", mem_addr, 32'h8000_1004);
      check("store.wdata", mem_wdata, 32'hDEAD_BEEF);
      check("store.wstrb", {28'h0, mem_wstrb}, 32'h3);
      check("store.we", {31'h0, mem_we}, 32'h1);
      check("store.valid", {31'h0, dm_valid}, (i == 3) ? 32'h1 : 32'h0);
      check("store.stall", {31'h0, stall_mem}, (i == 3) ? 32'h0 : 32'h1);
    end
    drive_slot();
    dm_req = 1'b0; dm_we = 1'b0; dm_wstrb = 4'h0;

    // Reset in the middle of a data access.
    drive_slot();
    dm_req = 1'b1; dm_addr = 32'h0000_0100; lat = 5;
    @(posedge clk);
    @(negedge clk);
    check("rstmid.busy", {31'h0, mem_req}, 32'h1);
    #2 reset = 1'b0;
    ready_force = 1'b1;
    #1;
    check("rstmid.req_drop", {31'h0, mem_req}, 32'h0);
    check("rstmid.no_valid", {31'h0, dm_valid}, 32'h0);
    drive_slot();
    drive_slot();
    reset = 1'b1; ready_force = 1'b0; lat = 1;
    @(posedge clk);
    @(negedge clk);
    check("rstmid.regrant", {31'h0, mem_req}, 32'h1);
    check("rstmid.addr", mem_addr, 32'h0000_0100);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = dm_valid;
    end
    check("rstmid.complete", {31'h0, seen}, 32'h1);
    drive_slot();
    dm_req = 1'b0;
    wait_idle("rstmid.settle");

    // Request withdrawn mid-access still completes.
    dm_req = 1'b1; dm_addr = 32'h0000_0200; lat = 2;
    @(posedge clk);
    #2 dm_req = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = dm_valid;
    end
    check("drop.valid", {31'h0, seen}, 32'h1);
    wait_idle("drop.settle");

    // mem_ready held high while idle is ignored.
    ready_force = 1'b1;
    @(negedge clk);
    check("rdyidle.if_valid", {31'h0, if_valid}, 32'h0);
    check("rdyidle.dm_valid", {31'h0, dm_valid}, 32'h0);
    drive_slot();
    if_req = 1'b1; if_addr = 32'h0000_0040; mem_rdata = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    check("rdyidle.first_valid", {31'h0, if_valid}, 32'h1);
    check("rdyidle.rdata", if_rdata, 32'h1234_5678);
    drive_slot();
    if_req = 1'b0; ready_force = 1'b0;
    drive_slot();
    drive_slot();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
